// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one memory read at a time and holds each word for decode.
// Optional misaligned-PC fault reporting is enabled by defining IFU_MISALIGN_CHK_EN.
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module ifu_fetch #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = `INSTR_WIDTH,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [ADDR_W-1:0]  mem_req_addr,
    input  logic               mem_rsp_valid,
    input  logic [INSTR_W-1:0] mem_rsp_data,
    input  logic               mem_rsp_err,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               out_err,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc
);

    localparam logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h0000_0013);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic                drop_rsp_q;
    logic                out_valid_q;
    logic [INSTR_W-1:0]  out_instr_q;
    logic [ADDR_W-1:0]   out_pc_q;
    logic                out_err_q;
    logic [ADDR_W-1:0]   pc_inc;
    logic                misaligned;
    logic                req_fire;

    assign pc_inc = pc_q + ADDR_W'(4);

`ifdef IFU_MISALIGN_CHK_EN
    assign misaligned = |pc_q[1:0];
`else
    assign misaligned = 1'b0;
`endif

    // Request is suppressed while reset is asserted and for a misaligned PC.
    assign mem_req_valid = rst_n && (state_q == S_REQ) && !misaligned;
    assign mem_req_addr  = pc_q;
    assign req_fire      = mem_req_valid && mem_req_ready;

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;
    assign out_err   = out_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            drop_rsp_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_instr_q <= NOP_INSTR;
            out_pc_q    <= '0;
            out_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_pc;
                        // An accepted request still returns a response that must be discarded.
                        if (req_fire) begin
                            state_q    <= S_WAIT;
                            drop_rsp_q <= 1'b1;
                        end
                    end else if (misaligned) begin
                        state_q     <= S_HOLD;
                        out_valid_q <= 1'b1;
                        out_instr_q <= '0;
                        out_pc_q    <= pc_q;
                        out_err_q   <= 1'b1;
                    end else if (req_fire) begin
                        state_q <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        if (drop_rsp_q || redirect_valid) begin
                            drop_rsp_q <= 1'b0;
                            state_q    <= S_REQ;
                            if (redirect_valid) begin
                                pc_q <= redirect_pc;
                            end
                        end else begin
                            state_q     <= S_HOLD;
                            out_valid_q <= 1'b1;
                            out_instr_q <= mem_rsp_data;
                            out_pc_q    <= pc_q;
                            out_err_q   <= mem_rsp_err;
                        end
                    end else if (redirect_valid) begin
                        pc_q       <= redirect_pc;
                        drop_rsp_q <= 1'b1;
                    end
                end

                S_HOLD: begin
                    if (out_ready || redirect_valid) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_REQ;
                        pc_q        <= redirect_valid ? redirect_pc : pc_inc;
                    end
                end

                default: begin
                    state_q <= S_REQ;
                end
            endcase
        end
    end

endmodule
